// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requesters onto one single-outstanding memory port.
// Load/store wins ties until fetch has waited STARVE_MAX consecutive ls grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_wstrb_q;
  logic          if_rvalid_q;
  logic [31:0]   if_rdata_q;
  logic          ls_rvalid_q;
  logic [31:0]   ls_rdata_q;
  logic          starve_full;
  logic          idle;

  // Grants are combinational so a requester sees acceptance in the cycle it asks.
  assign idle        = rst_ && (state_q == IDLE);
  assign starve_full = (starve_q == SMAX);
  assign if_gnt      = idle && if_req && (!ls_req || starve_full);
  assign ls_gnt      = idle && ls_req && !if_gnt;

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (ls_gnt && if_req && !starve_full) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE: begin
          if (if_gnt) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end else if (ls_gnt) begin
            state_q     <= BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ls_we;
            mem_addr_q  <= ls_addr;
            mem_wdata_q <= ls_wdata;
            mem_wstrb_q <= ls_wstrb;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mem_rdata;
          end
        end
        BUSY_LS: begin
          if (mem_ack) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            ls_rvalid_q <= 1'b1;
            // Stores complete with zero data so a stale read value never leaks out.
            ls_rdata_q  <= mem_we_q ? 32'd0 : mem_rdata;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;

endmodule
